// File: rtl/receptor_ascii_pkg.sv
// Shared definitions for the receptor_ascii telemetry receiver:
// UART state encoding, ASCII constants, frame geometry and small helpers.
package receptor_ascii_pkg;

  localparam int unsigned DIVISOR_DEF = 434;   // 50 MHz / 115200 baud
  localparam int unsigned FRAME_LEN   = 8;     // "CDU,CDU#"
  localparam int unsigned SEP_POS     = 3;     // position of the separator
  localparam int unsigned DATA_BITS   = 7;

  localparam logic [6:0] ASCII_0      = 7'h30;
  localparam logic [6:0] ASCII_9      = 7'h39;
  localparam logic [6:0] SEP_CHAR_DEF = 7'h2C; // ','
  localparam logic [6:0] END_CHAR_DEF = 7'h23; // '#'

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    START    = 3'd1,
    DADOS    = 3'd2,
    PARIDADE = 3'd3,
    STOP1    = 3'd4,
    STOP2    = 3'd5
  } uart_state_e;

  // True for an ASCII decimal digit
  function automatic logic is_digit(input logic [6:0] c);
    return (c >= ASCII_0) && (c <= ASCII_9);
  endfunction

  // Maps frame position 0,1,2,4,5,6 to shadow slot 0..5 (separator skipped)
  function automatic logic [2:0] shadow_slot(input logic [2:0] p);
    return (p < 3'(SEP_POS)) ? p : p - 3'd1;
  endfunction

endpackage

// File: rtl/rx_serial_7E2.sv
// 7E2 UART receiver: 2-FF line synchroniser, bit timer and framing FSM.
// Ports:
//   clock, reset      : system clock, async active-high reset
//   dado_serial       : raw serial line (idles high)
//   caractere[6:0]    : last character received, valid with char_valid
//   char_valid        : one-cycle pulse, character good (parity + stops)
//   char_erro         : one-cycle pulse, parity or stop-bit failure
module rx_serial_7E2
  import receptor_ascii_pkg::*;
#(
  parameter int unsigned DIVISOR = DIVISOR_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dado_serial,
  output logic [6:0] caractere,
  output logic       char_valid,
  output logic       char_erro
);

  localparam int unsigned CNT_W = $clog2(DIVISOR);
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIVISOR / 2 - 1);

  uart_state_e      state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [6:0]       shift_q, shift_d;
  logic             bad_q, bad_d;
  logic [6:0]       caractere_q, caractere_d;
  logic             valid_q, valid_d;
  logic             erro_q, erro_d;

  logic rx;
  logic tick;

  assign rx   = sync2_q;
  assign tick = (cnt_q == CNT_BIT);

  // Next-state: synchroniser shift, bit timing and character framing
  always_comb begin
    state_d     = state_q;
    sync1_d     = dado_serial;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    cnt_d       = cnt_q + CNT_W'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    bad_d       = bad_q;
    caractere_d = caractere_q;
    valid_d     = 1'b0;
    erro_d      = 1'b0;

    unique case (state_q)
      OCIOSO: begin
        cnt_d = '0;
        if (prev_q && !rx) state_d = START;
      end
      START: begin
        // Mid-start-bit check rejects short low glitches
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (rx) begin
            state_d = OCIOSO;
          end else begin
            state_d = DADOS;
            bit_d   = '0;
          end
        end
      end
      DADOS: begin
        if (tick) begin
          cnt_d   = '0;
          shift_d = {rx, shift_q[6:1]};
          if (bit_q == 3'(DATA_BITS - 1)) state_d = PARIDADE;
          else                            bit_d   = bit_q + 3'd1;
        end
      end
      PARIDADE: begin
        if (tick) begin
          cnt_d   = '0;
          bad_d   = (^shift_q) ^ rx;  // even parity over data + parity bit
          state_d = STOP1;
        end
      end
      STOP1: begin
        if (tick) begin
          cnt_d   = '0;
          bad_d   = bad_q | ~rx;
          state_d = STOP2;
        end
      end
      STOP2: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = OCIOSO;
          if (bad_q || !rx) begin
            erro_d = 1'b1;
          end else begin
            valid_d     = 1'b1;
            caractere_d = shift_q;
          end
        end
      end
      default: state_d = OCIOSO;
    endcase
  end

  // State and output registers; line synchroniser resets to idle high
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= OCIOSO;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      bad_q       <= 1'b0;
      caractere_q <= '0;
      valid_q     <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      bad_q       <= bad_d;
      caractere_q <= caractere_d;
      valid_q     <= valid_d;
      erro_q      <= erro_d;
    end
  end

  assign caractere  = caractere_q;
  assign char_valid = valid_q;
  assign char_erro  = erro_q;

endmodule

// File: rtl/receptor_ascii.sv
// Telemetry frame receiver for "CDU,CDU#" over 7E2 serial.
// Ports:
//   clock, reset             : system clock, async active-high reset
//   dado_serial              : serial line (idles high)
//   centena/dezena/unidade_angulo, _distancia : ASCII digits, last valid frame
//   pronto                   : one-cycle pulse, valid frame, fields updated
//   erro                     : one-cycle pulse, character or format error
//   db_estado                : frame position 0..7, 4'hF during erro pulse
module receptor_ascii
  import receptor_ascii_pkg::*;
#(
  parameter int unsigned DIVISOR  = DIVISOR_DEF,
  parameter logic [6:0]  SEP_CHAR = SEP_CHAR_DEF,
  parameter logic [6:0]  END_CHAR = END_CHAR_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dado_serial,
  output logic [6:0] centena_angulo,
  output logic [6:0] dezena_angulo,
  output logic [6:0] unidade_angulo,
  output logic [6:0] centena_distancia,
  output logic [6:0] dezena_distancia,
  output logic [6:0] unidade_distancia,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] db_estado
);

  localparam logic [2:0] LAST_POS = 3'(FRAME_LEN - 1);

  logic [6:0] caractere;
  logic       char_valid;
  logic       char_erro;

  logic [2:0]      p_q, p_d;
  logic [5:0][6:0] sh_q, sh_d;
  logic [5:0][6:0] out_q, out_d;
  logic            pronto_q, pronto_d;
  logic            erro_q, erro_d;
  logic [3:0]      db_q, db_d;
  logic            char_ok;

  rx_serial_7E2 #(
    .DIVISOR (DIVISOR)
  ) u_rx (
    .clock       (clock),
    .reset       (reset),
    .dado_serial (dado_serial),
    .caractere   (caractere),
    .char_valid  (char_valid),
    .char_erro   (char_erro)
  );

  // Character acceptance for the current frame position
  always_comb begin
    char_ok = 1'b0;
    if (p_q == 3'(SEP_POS))   char_ok = (caractere == SEP_CHAR);
    else if (p_q == LAST_POS) char_ok = (caractere == END_CHAR);
    else                      char_ok = is_digit(caractere);
  end

  // Frame parser: position tracking, shadow capture, publish on '#'
  always_comb begin
    p_d      = p_q;
    sh_d     = sh_q;
    out_d    = out_q;
    pronto_d = 1'b0;
    erro_d   = 1'b0;

    if (char_erro) begin
      erro_d = 1'b1;
      p_d    = '0;
    end else if (char_valid) begin
      if (!char_ok) begin
        // Offending character is dropped, not reused as position 0
        erro_d = 1'b1;
        p_d    = '0;
      end else if (p_q == LAST_POS) begin
        out_d    = sh_q;
        pronto_d = 1'b1;
        p_d      = '0;
      end else begin
        if (p_q != 3'(SEP_POS)) sh_d[shadow_slot(p_q)] = caractere;
        p_d = p_q + 3'd1;
      end
    end

    db_d = erro_d ? 4'hF : {1'b0, p_d};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p_q      <= '0;
      sh_q     <= {6{ASCII_0}};
      out_q    <= {6{ASCII_0}};
      pronto_q <= 1'b0;
      erro_q   <= 1'b0;
      db_q     <= '0;
    end else begin
      p_q      <= p_d;
      sh_q     <= sh_d;
      out_q    <= out_d;
      pronto_q <= pronto_d;
      erro_q   <= erro_d;
      db_q     <= db_d;
    end
  end

  assign centena_angulo    = out_q[0];
  assign dezena_angulo     = out_q[1];
  assign unidade_angulo    = out_q[2];
  assign centena_distancia = out_q[3];
  assign dezena_distancia  = out_q[4];
  assign unidade_distancia = out_q[5];
  assign pronto            = pronto_q;
  assign erro              = erro_q;
  assign db_estado         = db_q;

endmodule

// File: tb/tb_receptor_ascii.sv
// Directed bench for receptor_ascii: serial frames driven bit by bit, a
// reference frame parser queues expected pronto/erro events, and a monitor
// pops and compares them as the DUT pulses.
module tb_receptor_ascii;

  localparam int unsigned DIV = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       dado_serial = 1'b1;
  logic [6:0] centena_angulo, dezena_angulo, unidade_angulo;
  logic [6:0] centena_distancia, dezena_distancia, unidade_distancia;
  logic       pronto, erro;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;
  int n_pronto_obs = 0;
  int n_pronto_exp = 0;

  typedef struct packed {
    logic        err;
    logic [41:0] f;
  } ev_t;

  ev_t exp_q[$];

  // Reference parser state
  int          m_p;
  logic [6:0]  m_sh [6];
  logic [41:0] m_out;

  logic [41:0] obs_f;
  assign obs_f = {centena_angulo, dezena_angulo, unidade_angulo,
                  centena_distancia, dezena_distancia, unidade_distancia};

  receptor_ascii #(.DIVISOR(DIV)) dut (
    .clock             (clock),
    .reset             (reset),
    .dado_serial       (dado_serial),
    .centena_angulo    (centena_angulo),
    .dezena_angulo     (dezena_angulo),
    .unidade_angulo    (unidade_angulo),
    .centena_distancia (centena_distancia),
    .dezena_distancia  (dezena_distancia),
    .unidade_distancia (unidade_distancia),
    .pronto            (pronto),
    .erro              (erro),
    .db_estado         (db_estado)
  );

  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit dig(input logic [6:0] c);
    return (c >= 7'h30) && (c <= 7'h39);
  endfunction

  task automatic model_reset();
    m_p   = 0;
    m_out = {6{7'h30}};
    for (int i = 0; i < 6; i++) m_sh[i] = 7'h30;
  endtask

  // Advance the reference parser by one received character
  task automatic model_char(input logic [6:0] c, input bit bad_par);
    ev_t e;
    bit  ok;
    if (m_p == 3)      ok = (c == 7'h2C);
    else if (m_p == 7) ok = (c == 7'h23);
    else               ok = dig(c);
    if (bad_par || !ok) begin
      m_p   = 0;
      e.err = 1'b1;
      e.f   = m_out;
      exp_q.push_back(e);
    end else if (m_p == 7) begin
      m_out = {m_sh[0], m_sh[1], m_sh[2], m_sh[3], m_sh[4], m_sh[5]};
      m_p   = 0;
      e.err = 1'b0;
      e.f   = m_out;
      exp_q.push_back(e);
      n_pronto_exp++;
    end else begin
      if (m_p < 3)      m_sh[m_p]     = c;
      else if (m_p > 3) m_sh[m_p - 1] = c;
      m_p++;
    end
  endtask

  task automatic send_bit(input logic b);
    dado_serial = b;
    repeat (DIV) @(negedge clock);
  endtask

  task automatic send_char(input logic [6:0] c, input bit bad_par);
    model_char(c, bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 7; i++) send_bit(c[i]);
    send_bit((^c) ^ bad_par);
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  // bad_idx selects a character whose parity bit is inverted (-1: none)
  task automatic send_frame(input string s, input int bad_idx);
    byte b;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      send_char(b[6:0], i == bad_idx);
    end
  endtask

  task automatic idle(input int n);
    dado_serial = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  // Bounded wait for all queued events to be consumed
  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: pulses compared against the scoreboard away from the active edge
  always @(negedge clock) begin
    ev_t e;
    if (!reset) begin
      if (pronto && erro) check("pronto_and_erro", 64'd1, 64'd0);
      if (pronto || erro) begin
        if (pronto) n_pronto_obs++;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {62'd0, pronto, erro}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind_erro", 64'(erro), 64'(e.err));
          check("event_fields", 64'(obs_f), 64'(e.f));
          if (erro) check("db_estado_err", 64'(db_estado), 64'hF);
        end
      end
    end
  end

  initial begin
    #(60000 * 20);
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_fields", 64'(obs_f), 64'({6{7'h30}}));
    check("rst_pronto", 64'(pronto), 64'd0);
    check("rst_erro", 64'(erro), 64'd0);
    check("rst_db", 64'(db_estado), 64'd0);
    reset = 1'b0;
    idle(20);

    // Basic frame
    send_frame("147,297#", -1);
    idle(10);
    drain("f1_drain");
    check("f1_fields", 64'(obs_f),
          64'({7'h31, 7'h34, 7'h37, 7'h32, 7'h39, 7'h37}));
    check("f1_db_idle", 64'(db_estado), 64'd0);

    // Format error: outputs hold, then a good frame updates
    send_frame("14A,297#", -1);
    idle(10);
    drain("f2_drain");
    check("f2_hold", 64'(obs_f),
          64'({7'h31, 7'h34, 7'h37, 7'h32, 7'h39, 7'h37}));
    send_frame("090,015#", -1);
    idle(10);
    drain("f3_drain");
    check("f3_fields", 64'(obs_f),
          64'({7'h30, 7'h39, 7'h30, 7'h30, 7'h31, 7'h35}));

    // Parity error on the second character
    send_frame("555,123#", 1);
    idle(10);
    drain("f4_drain");
    check("f4_hold", 64'(obs_f),
          64'({7'h30, 7'h39, 7'h30, 7'h30, 7'h31, 7'h35}));
    send_frame("321,654#", -1);
    idle(10);
    drain("f5_drain");
    check("f5_fields", 64'(obs_f),
          64'({7'h33, 7'h32, 7'h31, 7'h36, 7'h35, 7'h34}));

    // Short low glitch on idle line is ignored
    dado_serial = 1'b0;
    repeat (5) @(negedge clock);
    idle(4 * DIV);
    check("glitch_db", 64'(db_estado), 64'd0);
    send_frame("777,888#", -1);
    idle(10);
    drain("f6_drain");
    check("f6_fields", 64'(obs_f),
          64'({7'h37, 7'h37, 7'h37, 7'h38, 7'h38, 7'h38}));

    // Back-to-back frames with no idle between characters
    send_frame("111,222#", -1);
    send_frame("359,400#", -1);
    idle(10);
    drain("f78_drain");
    check("f8_fields", 64'(obs_f),
          64'({7'h33, 7'h35, 7'h39, 7'h34, 7'h30, 7'h30}));

    // Reset after four characters of a frame
    send_frame("888,", -1);
    idle(5);
    check("mid_db", 64'(db_estado), 64'd4);
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clock);
    check("mid_rst_fields", 64'(obs_f), 64'({6{7'h30}}));
    check("mid_rst_db", 64'(db_estado), 64'd0);
    reset = 1'b0;
    idle(20);
    check("post_rst_pronto", 64'(pronto), 64'd0);
    send_frame("246,813#", -1);
    idle(10);
    drain("f9_drain");
    check("f9_fields", 64'(obs_f),
          64'({7'h32, 7'h34, 7'h36, 7'h38, 7'h31, 7'h33}));

    check("pronto_count", 64'(n_pronto_obs), 64'(n_pronto_exp));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
